// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD requester: datapath width, FSM state encoding, default ack timeout.
package gcd_pkg;

   localparam int GCD_WIDTH       = 16;
   localparam int GCD_TIMEOUT_DEF = 1023;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_REQ = 3'd1,
      A_REL = 3'd2,
      B_REQ = 3'd3,
      B_REL = 3'd4,
      ZERO  = 3'd5,
      DONE  = 3'd6
   } state_t;

   // States in which the requester is waiting on an ack edge.
   function automatic logic is_wait(state_t s);
      return (s == A_REQ) || (s == A_REL) || (s == B_REQ) || (s == B_REL);
   endfunction

endpackage

// File: rtl/gcd_requester_if.sv
// Four-phase req/ack bus to the GCD unit: operands go out on AB, the result comes back on C.
interface gcd_requester_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
);
   logic             req;
   logic             ack;
   logic [WIDTH-1:0] AB;
   logic [WIDTH-1:0] C;

   modport master (output req, output AB, input ack, input C);
   modport slave  (input req, input AB, output ack, output C);
endinterface

// File: rtl/gcd_req_watchdog.sv
// Ack-wait watchdog, built only with GCD_REQ_TIMEOUT_EN: counts waited cycles since the last state change.
// A clear in a waiting cycle counts that cycle as the first one; the count saturates at TIMEOUT.
`ifdef GCD_REQ_TIMEOUT_EN
module gcd_req_watchdog
   import gcd_pkg::*;
#(
   parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CW'(TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = en ? CW'(1) : '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule
`endif

// File: rtl/gcd_requester.sv
// Initiator of the GCD req/ack handshake: presents A then B on AB, captures C, pulses done; outputs lag state by one cycle.
// Optional ack watchdog (abort to IDLE with sticky err) is built when GCD_REQ_TIMEOUT_EN is defined.
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int WIDTH   = GCD_WIDTH,
   parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err,
   gcd_requester_if.master  gcd
);
   if (TIMEOUT < 1 || WIDTH < 1) begin : g_bad_cfg
      $error("gcd_requester: TIMEOUT and WIDTH must be at least 1");
   end

   state_t           state_q, state_d, state_nxt;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ab_q, ab_d, result_q, result_d;
   logic             req_q, req_d, busy_q, busy_d, done_q, done_d;
   logic             accept, timeout;

   always_comb begin
      state_nxt = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               a_d       = a_in;
               b_d       = b_in;
               state_nxt = (a_in == '0 || b_in == '0) ? ZERO : A_REQ;
            end
         end
         A_REQ: if (gcd.ack)  state_nxt = A_REL;
         A_REL: if (!gcd.ack) state_nxt = B_REQ;
         B_REQ: begin
            if (gcd.ack) begin
               result_d  = gcd.C;
               state_nxt = B_REL;
            end
         end
         B_REL: if (!gcd.ack) state_nxt = DONE;
         ZERO: begin
            result_d  = (a_q == '0) ? b_q : a_q;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // An aborted wait must not disturb the last good result.
      state_d = state_nxt;
      if (timeout) begin
         state_d  = IDLE;
         result_d = result_q;
      end

      req_d  = ((state_q == A_REQ) || (state_q == B_REQ)) && !timeout;
      ab_d   = (state_q == A_REQ) ? a_q : (state_q == B_REQ) ? b_q : ab_q;
      busy_d = (state_d != IDLE);
      done_d = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ab_q     <= '0;
         result_q <= '0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ab_q     <= ab_d;
         result_q <= result_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef GCD_REQ_TIMEOUT_EN
   logic expired, err_q, err_d;

   gcd_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_nxt != state_q),
      .en      (is_wait(state_nxt)),
      .expired (expired)
   );

   assign timeout = expired && is_wait(state_q);

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = 1'b0;
      end else if (timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   assign gcd.req = req_q;
   assign gcd.AB  = ab_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester against a behavioural GCD responder with programmable ack delay.
module tb_gcd_requester;
   import gcd_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           k;
      bit           zpath;
      logic [W-1:0] exp;
   } vec_t;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in  = '0;
   logic [W-1:0] b_in  = '0;
   logic         busy, done, err;
   logic [W-1:0] result;

   gcd_requester_if #(.WIDTH(W)) bus ();

   gcd_requester #(.WIDTH(W), .TIMEOUT(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err),
      .gcd    (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural GCD unit: answers each req edge after rsp_k extra cycles.
   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] p = x, q = y, t;
      while (q != '0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   int           rsp_k  = 3;
   bit           rsp_en = 1'b1;
   int           rsp_cnt = 0;
   bit           rsp_phase = 1'b0;
   logic [W-1:0] rsp_a = '0;

   always @(negedge clk) begin
      if (reset || !rsp_en) begin
         bus.ack   = 1'b0;
         bus.C     = '0;
         rsp_cnt   = 0;
         rsp_phase = 1'b0;
      end else if (bus.ack != bus.req) begin
         if (rsp_cnt >= rsp_k) begin
            if (bus.req) begin
               if (!rsp_phase) rsp_a = bus.AB;
               else            bus.C = gcd_ref(rsp_a, bus.AB);
               rsp_phase = ~rsp_phase;
            end
            bus.ack = bus.req;
            rsp_cnt = 0;
         end else begin
            rsp_cnt++;
         end
      end
   end

   // Bus monitor: done pulses, req rising edges (cycle and AB), AB changes while req held high.
   int           done_cnt  = 0;
   int           rise_cnt  = 0;
   int           ab_glitch = 0;
   int           rise_cyc[$];
   logic [W-1:0] rise_ab[$];
   logic         req_prev = 1'b0;
   logic [W-1:0] ab_prev  = '0;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (bus.req === 1'b1 && !req_prev) begin
         rise_cnt++;
         rise_cyc.push_back(cyc);
         rise_ab.push_back(bus.AB);
      end
      if (bus.req === 1'b1 && req_prev && bus.AB !== ab_prev) ab_glitch++;
      req_prev = (bus.req === 1'b1);
      ab_prev  = bus.AB;
   end

   task automatic wait_done(input int bound, output bit ok, output int dcyc);
      ok   = 1'b0;
      dcyc = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok   = 1'b1;
            dcyc = cyc;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                         output int acc, output logic busy_s);
      rsp_k = k;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1 acc = cyc;
      @(negedge clk);
      start  = 1'b0;
      busy_s = busy;
   endtask

   vec_t vecs[8];

   initial begin
      int           acc, dcyc, bd, br, bg, n_req, n_err;
      int           dc[3];
      bit           ok;
      logic         busy_s;
      logic [W-1:0] ra[3], rb[3], rexp[3];

      vecs[0] = '{a: 16'd48,    b: 16'd18,  k: 3, zpath: 1'b0, exp: 16'd6};
      vecs[1] = '{a: 16'd1071,  b: 16'd462, k: 1, zpath: 1'b0, exp: 16'd21};
      vecs[2] = '{a: 16'd17,    b: 16'd5,   k: 2, zpath: 1'b0, exp: 16'd1};
      vecs[3] = '{a: 16'd65535, b: 16'd255, k: 0, zpath: 1'b0, exp: 16'd255};
      vecs[4] = '{a: 16'd0,     b: 16'd35,  k: 3, zpath: 1'b1, exp: 16'd35};
      vecs[5] = '{a: 16'd0,     b: 16'd0,   k: 3, zpath: 1'b1, exp: 16'd0};
      vecs[6] = '{a: 16'd12,    b: 16'd0,   k: 3, zpath: 1'b1, exp: 16'd12};
      vecs[7] = '{a: 16'd7,     b: 16'd7,   k: 5, zpath: 1'b0, exp: 16'd7};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst req",    32'(bus.req), 32'd0);
      check("rst AB",     32'(bus.AB),  32'd0);
      check("rst busy",   32'(busy),    32'd0);
      check("rst done",   32'(done),    32'd0);
      check("rst result", 32'(result),  32'd0);
      check("rst err",    32'(err),     32'd0);
      check("rst state",  32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         bd = done_cnt; br = rise_cnt; bg = ab_glitch;
         run_op(vecs[i].a, vecs[i].b, vecs[i].k, acc, busy_s);
         check($sformatf("v%0d busy after start", i), 32'(busy_s), 32'd1);
         wait_done(400, ok, dcyc);
         check($sformatf("v%0d done seen", i), 32'(ok), 32'd1);
         check($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].exp));
         check($sformatf("v%0d busy at done", i), 32'(busy), 32'd0);
         repeat (4) @(negedge clk);
         check($sformatf("v%0d done pulses", i), 32'(done_cnt - bd), 32'd1);
         if (vecs[i].zpath) begin
            check($sformatf("v%0d req rises", i), 32'(rise_cnt - br), 32'd0);
            check($sformatf("v%0d zero latency", i), 32'(dcyc - acc), 32'd2);
         end else begin
            check($sformatf("v%0d req rises", i), 32'(rise_cnt - br), 32'd2);
            check($sformatf("v%0d req latency", i), 32'(rise_cyc[br] - acc), 32'd1);
            check($sformatf("v%0d AB in A phase", i), 32'(rise_ab[br]), 32'(vecs[i].a));
            check($sformatf("v%0d AB in B phase", i), 32'(rise_ab[br + 1]), 32'(vecs[i].b));
            check($sformatf("v%0d AB stable under req", i), 32'(ab_glitch - bg), 32'd0);
         end
      end

      // start while busy is ignored
      bd = done_cnt; br = rise_cnt;
      run_op(16'd100, 16'd75, 3, acc, busy_s);
      repeat (3) @(negedge clk);
      a_in = 16'd9; b_in = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(400, ok, dcyc);
      check("busy-start done seen", 32'(ok), 32'd1);
      check("busy-start result", 32'(result), 32'd25);
      repeat (10) @(negedge clk);
      check("busy-start done pulses", 32'(done_cnt - bd), 32'd1);
      check("busy-start req rises", 32'(rise_cnt - br), 32'd2);
      check("busy-start AB in B phase", 32'(rise_ab[br + 1]), 32'd75);

      // Reset while in B_REQ, then recover
      br = rise_cnt;
      run_op(16'd1071, 16'd462, 3, acc, busy_s);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rise_cnt - br >= 2) begin ok = 1'b1; break; end
      end
      check("mid-reset reached B_REQ", 32'(ok), 32'd1);
      check("mid-reset req high before", 32'(bus.req), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid-reset req",    32'(bus.req), 32'd0);
      check("mid-reset busy",   32'(busy),    32'd0);
      check("mid-reset result", 32'(result),  32'd0);
      check("mid-reset done",   32'(done),    32'd0);
      check("mid-reset state",  32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      run_op(16'd21, 16'd14, 2, acc, busy_s);
      wait_done(400, ok, dcyc);
      check("post-reset done seen", 32'(ok), 32'd1);
      check("post-reset result", 32'(result), 32'd7);

      // Back-to-back with start held high
      ra   = '{16'd1071, 16'd17, 16'd65535};
      rb   = '{16'd462,  16'd5,  16'd255};
      rexp = '{16'd21,   16'd1,  16'd255};
      repeat (3) @(negedge clk);
      bd = done_cnt; br = rise_cnt; rsp_k = 1;
      a_in = ra[0]; b_in = rb[0]; start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         wait_done(400, ok, dc[j]);
         check($sformatf("b2b%0d done seen", j), 32'(ok), 32'd1);
         check($sformatf("b2b%0d result", j), 32'(result), 32'(rexp[j]));
         if (j < 2) begin
            a_in = ra[j + 1];
            b_in = rb[j + 1];
         end else begin
            start = 1'b0;
         end
      end
      repeat (5) @(negedge clk);
      check("b2b done pulses", 32'(done_cnt - bd), 32'd3);
      check("b2b req rises", 32'(rise_cnt - br), 32'd6);
      check("b2b gap after done 0", 32'(rise_cyc[br + 2] - dc[0]), 32'd2);
      check("b2b gap after done 1", 32'(rise_cyc[br + 4] - dc[1]), 32'd2);

      // Responder never acks
      bd = done_cnt;
      rsp_en = 1'b0;
      run_op(16'd5, 16'd3, 0, acc, busy_s);
`ifdef GCD_REQ_TIMEOUT_EN
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (err === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("timeout err raised", 32'(ok), 32'd1);
      check("timeout cycles in A_REQ", 32'(cyc - acc), 32'd8);
      check("timeout req", 32'(bus.req), 32'd0);
      check("timeout busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("timeout err sticky", 32'(err), 32'd1);
      check("timeout no done", 32'(done_cnt - bd), 32'd0);
      check("timeout result kept", 32'(result), 32'd255);
`else
      n_req = 0; n_err = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.req === 1'b1) n_req++;
         if (err !== 1'b0) n_err++;
      end
      check("no-timeout req held", 32'(n_req), 32'd100);
      check("no-timeout err low", 32'(n_err), 32'd0);
      check("no-timeout no done", 32'(done_cnt - bd), 32'd0);
      check("no-timeout busy", 32'(busy), 32'd1);
`endif
      reset = 1'b1;
      rsp_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
